// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Fetch stage in front of the control unit. It owns the PC, issues one
// instruction-memory read at a time and holds the returned word until
// decode accepts it. A redirect loads a new PC and squashes any fetch
// still in flight. A halt opcode (3'b111) stops fetching until reset.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | after reset; waiting for start
// S_FETCH | imem_req high for this single cycle at imem_addr
// S_WAIT  | request issued; waiting for imem_rvalid (dropped if discard)
// S_HOLD  | instr_valid high until decode takes the word or a redirect
// S_HALT  | halt opcode fetched; sticky until reset
module instr_fetch_unit #(
    parameter int                ADDR_W     = 8,
    parameter int                INSTR_W    = 16,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [2:0]         opcode_o,
    output logic [ADDR_W-1:0]  pc_out_o,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_addr_i,
    output logic               halted_o
);

    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t               state_q;
    logic [ADDR_W-1:0]    pc_q;
    logic                 discard_q;
    logic                 imem_req_q;
    logic [ADDR_W-1:0]    imem_addr_q;
    logic                 instr_valid_q;
    logic [INSTR_W-1:0]   instr_q;
    logic [2:0]           opcode_q;
    logic [ADDR_W-1:0]    pc_out_q;
    logic                 halted_q;

    logic [ADDR_W-1:0]    pc_inc_d;
    logic [2:0]           rd_opcode_d;

    // Next sequential PC (wraps naturally at 2^ADDR_W) and opcode of the returning word
    always_comb begin
        pc_inc_d    = pc_q + ADDR_W'(1);
        rd_opcode_d = imem_rdata_i[INSTR_W-1 -: 3];
    end

    // Fetch FSM; every output is a register updated alongside the state
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            pc_q          <= START_ADDR;
            discard_q     <= 1'b0;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= '0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            opcode_q      <= 3'b000;
            pc_out_q      <= '0;
            halted_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q     <= S_FETCH;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= pc_q;
                    end
                end

                S_FETCH: begin
                    // The request at the old PC is already on the bus, so a
                    // redirect here can only mark its answer as stale.
                    imem_req_q <= 1'b0;
                    state_q    <= S_WAIT;
                    if (redirect_i) begin
                        pc_q      <= redirect_addr_i;
                        discard_q <= 1'b1;
                    end
                end

                S_WAIT: begin
                    if (redirect_i) begin
                        pc_q <= redirect_addr_i;
                        if (imem_rvalid_i) begin
                            // Word arrives with the jump: drop it and refetch at the target
                            discard_q   <= 1'b0;
                            state_q     <= S_FETCH;
                            imem_req_q  <= 1'b1;
                            imem_addr_q <= redirect_addr_i;
                        end else begin
                            discard_q <= 1'b1;
                        end
                    end else if (imem_rvalid_i) begin
                        if (discard_q) begin
                            discard_q   <= 1'b0;
                            state_q     <= S_FETCH;
                            imem_req_q  <= 1'b1;
                            imem_addr_q <= pc_q;
                        end else begin
                            instr_q  <= imem_rdata_i;
                            opcode_q <= rd_opcode_d;
                            pc_out_q <= pc_q;
                            pc_q     <= pc_inc_d;
                            if (rd_opcode_d == OP_HALT) begin
                                state_q  <= S_HALT;
                                halted_q <= 1'b1;
                            end else begin
                                state_q       <= S_HOLD;
                                instr_valid_q <= 1'b1;
                            end
                        end
                    end
                end

                S_HOLD: begin
                    // Redirect wins over ready; either way the held word is released
                    if (redirect_i) begin
                        pc_q          <= redirect_addr_i;
                        instr_valid_q <= 1'b0;
                        state_q       <= S_FETCH;
                        imem_req_q    <= 1'b1;
                        imem_addr_q   <= redirect_addr_i;
                    end else if (instr_ready_i) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= S_FETCH;
                        imem_req_q    <= 1'b1;
                        imem_addr_q   <= pc_q;
                    end
                end

                S_HALT: begin
                    imem_req_q <= 1'b0;
                    halted_q   <= 1'b1;
                end

                default: begin
                    state_q    <= S_IDLE;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Drive ports straight from the registers
    always_comb begin
        imem_req_o    = imem_req_q;
        imem_addr_o   = imem_addr_q;
        instr_valid_o = instr_valid_q;
        instr_o       = instr_q;
        opcode_o      = opcode_q;
        pc_out_o      = pc_out_q;
        halted_o      = halted_q;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
// Drives instr_fetch_unit with a small instruction-memory model, a table of
// ordinary fetches and hand-written redirect / halt / reset sequences.
// Words handed to the DUT are pushed to a scoreboard and popped when the
// DUT presents them on the decode side.
module tb_instr_fetch_unit;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic        imem_req_o;
    logic [7:0]  imem_addr_o;
    logic        imem_rvalid_i;
    logic [15:0] imem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [15:0] instr_o;
    logic [2:0]  opcode_o;
    logic [7:0]  pc_out_o;
    logic        redirect_i;
    logic [7:0]  redirect_addr_i;
    logic        halted_o;

    instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .START_ADDR(8'h00)) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .start_i         (start_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .instr_o         (instr_o),
        .opcode_o        (opcode_o),
        .pc_out_o        (pc_out_o),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .halted_o        (halted_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] word;
        int          lat;
        int          hold;
        logic [2:0]  op;
    } vec_t;

    typedef struct {
        logic [15:0] instr;
        logic [2:0]  op;
        logic [7:0]  pc;
    } exp_t;

    vec_t        vecs [4];
    exp_t        sb [$];
    exp_t        cur;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_req(input logic [7:0] addr);
        chk("imem_req", 32'(imem_req_o), 32'd1);
        chk("imem_addr", 32'(imem_addr_o), 32'(addr));
    endtask

    // Answer the request visible now after lat cycles; push the word if it should surface
    task automatic serve(input logic [7:0] addr, input logic [15:0] word, input int lat, input bit keep);
        exp_t e;
        expect_req(addr);
        for (int i = 0; i < lat; i++) begin
            tick();
            chk("req_one_cycle", 32'(imem_req_o), 32'd0);
        end
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = word;
        if (keep) begin
            e.instr = word;
            e.op    = word[15:13];
            e.pc    = addr;
            sb.push_back(e);
        end
        tick();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 16'h0;
    endtask

    task automatic check_hold();
        chk("instr_valid", 32'(instr_valid_o), 32'd1);
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got valid word %0h expected none", instr_o);
        end else begin
            cur = sb.pop_front();
            chk("instr", 32'(instr_o), 32'(cur.instr));
            chk("opcode", 32'(opcode_o), 32'(cur.op));
            chk("pc_out", 32'(pc_out_o), 32'(cur.pc));
        end
    endtask

    task automatic release_hold(input int delay);
        for (int i = 0; i < delay; i++) begin
            instr_ready_i = 1'b0;
            tick();
            chk("bp_valid", 32'(instr_valid_o), 32'd1);
            chk("bp_instr", 32'(instr_o), 32'(cur.instr));
            chk("bp_pc_out", 32'(pc_out_o), 32'(cur.pc));
            chk("bp_no_req", 32'(imem_req_o), 32'd0);
        end
        instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0;
        chk("valid_drop", 32'(instr_valid_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{addr: 8'h01, word: 16'h2ABC, lat: 1, hold: 0, op: 3'b001};
        vecs[1] = '{addr: 8'h02, word: 16'h4123, lat: 3, hold: 5, op: 3'b010};
        vecs[2] = '{addr: 8'h03, word: 16'hC0FF, lat: 2, hold: 1, op: 3'b110};
        vecs[3] = '{addr: 8'h04, word: 16'h0000, lat: 1, hold: 2, op: 3'b000};

        reset_i         = 1'b1;
        start_i         = 1'b0;
        imem_rvalid_i   = 1'b0;
        imem_rdata_i    = 16'h0;
        instr_ready_i   = 1'b0;
        redirect_i      = 1'b0;
        redirect_addr_i = 8'h00;
        repeat (2) tick();
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_addr", 32'(imem_addr_o), 32'd0);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_instr", 32'(instr_o), 32'd0);
        chk("rst_opcode", 32'(opcode_o), 32'd0);
        chk("rst_pc_out", 32'(pc_out_o), 32'd0);
        chk("rst_halted", 32'(halted_o), 32'd0);
        reset_i = 1'b0;
        tick();
        chk("idle_no_req", 32'(imem_req_o), 32'd0);

        // IDLE ignores redirect and rvalid
        redirect_i      = 1'b1;
        redirect_addr_i = 8'h55;
        imem_rvalid_i   = 1'b1;
        imem_rdata_i    = 16'h8888;
        tick();
        redirect_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        chk("idle_ign_req", 32'(imem_req_o), 32'd0);
        chk("idle_ign_valid", 32'(instr_valid_o), 32'd0);

        // Basic fetch: req one cycle after start, word two cycles after req
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        serve(8'h00, 16'h8000, 2, 1'b1);
        check_hold();
        release_hold(0);

        // Table of ordinary fetches, including a 5-cycle backpressure case
        for (int v = 0; v < 4; v++) begin
            serve(vecs[v].addr, vecs[v].word, vecs[v].lat, 1'b1);
            chk("tbl_opcode", 32'(opcode_o), 32'(vecs[v].op));
            check_hold();
            release_hold(vecs[v].hold);
        end

        // Redirect in WAIT at pc=5, stale word two cycles later
        expect_req(8'h05);
        tick();
        chk("wait_req_low", 32'(imem_req_o), 32'd0);
        redirect_i      = 1'b1;
        redirect_addr_i = 8'h40;
        tick();
        redirect_i = 1'b0;
        chk("squash_valid_a", 32'(instr_valid_o), 32'd0);
        tick();
        chk("squash_valid_b", 32'(instr_valid_o), 32'd0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 16'h7777;
        tick();
        imem_rvalid_i = 1'b0;
        chk("squash_valid_c", 32'(instr_valid_o), 32'd0);

        // Jump from HOLD with ready to 0x40
        serve(8'h40, 16'h6000, 1, 1'b1);
        check_hold();
        instr_ready_i   = 1'b1;
        redirect_i      = 1'b1;
        redirect_addr_i = 8'h40;
        tick();
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        chk("jump_valid", 32'(instr_valid_o), 32'd0);
        serve(8'h40, 16'h2222, 1, 1'b1);
        check_hold();
        release_hold(0);

        // Redirect during FETCH: old-address word is still answered, then dropped
        expect_req(8'h41);
        redirect_i      = 1'b1;
        redirect_addr_i = 8'hFF;
        tick();
        redirect_i = 1'b0;
        chk("fetch_redir_req", 32'(imem_req_o), 32'd0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 16'h2AAA;
        tick();
        imem_rvalid_i = 1'b0;
        chk("fetch_redir_valid", 32'(instr_valid_o), 32'd0);

        // Fetch at 0xFF, PC wraps to 0x00
        serve(8'hFF, 16'h3000, 1, 1'b1);
        check_hold();
        release_hold(1);

        // Redirect in HOLD without ready
        serve(8'h00, 16'h4444, 1, 1'b1);
        check_hold();
        redirect_i      = 1'b1;
        redirect_addr_i = 8'h10;
        tick();
        redirect_i = 1'b0;
        chk("hold_redir_valid", 32'(instr_valid_o), 32'd0);

        // Redirect coinciding with rvalid in WAIT
        expect_req(8'h10);
        tick();
        imem_rvalid_i   = 1'b1;
        imem_rdata_i    = 16'h5555;
        redirect_i      = 1'b1;
        redirect_addr_i = 8'h20;
        tick();
        imem_rvalid_i = 1'b0;
        redirect_i    = 1'b0;
        chk("wait_both_valid", 32'(instr_valid_o), 32'd0);

        // Reset while in WAIT; the late word must be ignored
        expect_req(8'h20);
        tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("midrst_req", 32'(imem_req_o), 32'd0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 16'h1234;
        tick();
        imem_rvalid_i = 1'b0;
        chk("midrst_valid", 32'(instr_valid_o), 32'd0);
        chk("midrst_opcode", 32'(opcode_o), 32'd0);
        tick();
        chk("midrst_idle_req", 32'(imem_req_o), 32'd0);
        chk("midrst_idle_valid", 32'(instr_valid_o), 32'd0);

        // Halt opcode stops fetch; start and redirect ignored
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        serve(8'h00, 16'hE000, 1, 1'b0);
        chk("halted", 32'(halted_o), 32'd1);
        chk("halt_valid", 32'(instr_valid_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            start_i         = 1'b1;
            redirect_i      = 1'b1;
            redirect_addr_i = 8'h33;
            tick();
            chk("halt_no_req", 32'(imem_req_o), 32'd0);
            chk("halt_sticky", 32'(halted_o), 32'd1);
            chk("halt_no_valid", 32'(instr_valid_o), 32'd0);
        end
        start_i    = 1'b0;
        redirect_i = 1'b0;
        reset_i    = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("halt_rst_halted", 32'(halted_o), 32'd0);
        chk("halt_rst_req", 32'(imem_req_o), 32'd0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        expect_req(8'h00);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
